// File: rtl/midi_pkg.sv
// Shared constants and state encodings for the MIDI decoder.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [7:0] SYSEX_LO = 8'hF0;
    localparam logic [7:0] RT_LO    = 8'hF8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        P_IGNORE,
        P_NOTE,
        P_VEL
    } p_state_t;

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 2-flop synchroniser, mid-bit sampling, stop-bit check.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic            meta, sync;
    rx_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n, data_n;
    logic            valid_n, ferr_n;

    // Synchroniser; resets to the idle-high line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= midi_in;
            sync <= meta;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            byte_data  <= data_n;
            byte_valid <= valid_n;
            frame_err  <= ferr_n;
        end
    end

    // Next-state logic; the counter free-runs and is zeroed at each sample point.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = byte_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (!sync) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_n     = '0;
                    shreg_n   = {sync, shreg[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL) begin
                    cnt_n = '0;
                    if (sync) begin
                        valid_n = 1'b1;
                        data_n  = shreg;
                        state_n = RX_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_n = '0;
                if (sync) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/midi_poly_decoder.sv
// MIDI note parser with running status and a NUM_VOICES-slot held-note table.
module midi_poly_decoder
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 128,
    parameter int NUM_VOICES   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      midi_in,
    input  logic [3:0]                chan_sel,
    input  logic                      omni,
    output logic                      byte_valid,
    output logic [7:0]                byte_data,
    output logic                      frame_err,
    output logic                      overflow,
    output logic [NUM_VOICES-1:0]     voice_valid,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [7*NUM_VOICES-1:0]   voice_vel
);

    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    p_state_t                    p_state, p_state_n;
    logic [3:0]                  rs_type;
    logic [6:0]                  note_lat;
    logic [NUM_VOICES-1:0][6:0]  note_q, vel_q;
    logic                        match_hit, free_hit;
    logic [IW-1:0]               match_idx, free_idx;
    logic                        is_note_msg, chan_ok, exec, note_on;

    midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .midi_in    (midi_in),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign voice_note  = note_q;
    assign voice_vel   = vel_q;
    assign is_note_msg = (byte_data[7:4] == NOTE_ON) || (byte_data[7:4] == NOTE_OFF);
    assign chan_ok     = omni || (byte_data[3:0] == chan_sel);
    assign exec        = byte_valid && !byte_data[7] && (p_state == P_VEL);
    assign note_on     = (rs_type == NOTE_ON) && (byte_data[6:0] != 7'd0);

    // Parser next state; real-time bytes fall through and leave everything untouched.
    always_comb begin
        p_state_n = p_state;
        if (byte_valid) begin
            if (byte_data[7]) begin
                if (byte_data < SYSEX_LO)
                    p_state_n = (is_note_msg && chan_ok) ? P_NOTE : P_IGNORE;
                else if (byte_data < RT_LO)
                    p_state_n = P_IGNORE;
            end else begin
                case (p_state)
                    P_NOTE:  p_state_n = P_VEL;
                    P_VEL:   p_state_n = P_NOTE;
                    default: p_state_n = p_state;
                endcase
            end
        end
    end

    // Priority search: lowest slot holding the latched note, lowest free slot.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!match_hit && voice_valid[i] && (note_q[i] == note_lat)) begin
                match_hit = 1'b1;
                match_idx = IW'(i);
            end
            if (!free_hit && !voice_valid[i]) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // Parser registers and voice table update on the velocity byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_state     <= P_IGNORE;
            rs_type     <= 4'h0;
            note_lat    <= '0;
            overflow    <= 1'b0;
            voice_valid <= '0;
            note_q      <= '0;
            vel_q       <= '0;
        end else begin
            overflow <= 1'b0;
            p_state  <= p_state_n;
            if (byte_valid && byte_data[7] && (byte_data < RT_LO))
                rs_type <= (byte_data < SYSEX_LO) ? byte_data[7:4] : 4'h0;
            if (byte_valid && !byte_data[7] && (p_state == P_NOTE))
                note_lat <= byte_data[6:0];
            if (exec) begin
                if (note_on) begin
                    if (match_hit) begin
                        vel_q[match_idx] <= byte_data[6:0];
                    end else if (free_hit) begin
                        voice_valid[free_idx] <= 1'b1;
                        note_q[free_idx]      <= note_lat;
                        vel_q[free_idx]       <= byte_data[6:0];
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (match_hit) begin
                    voice_valid[match_idx] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_poly_decoder.sv
// Self-checking bench: byte scoreboard with arrival-cycle check plus voice-table checks.
module tb_midi_poly_decoder;

    localparam int CPB = 16;
    localparam int NV  = 4;
    // 2 sync flops + IDLE edge detect + half bit + 9 full bits
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          midi_in = 1'b1;
    logic [3:0]    chan_sel = 4'h0;
    logic          omni = 1'b0;
    logic          byte_valid, frame_err, overflow;
    logic [7:0]    byte_data;
    logic [NV-1:0] voice_valid;
    logic [7*NV-1:0] voice_note, voice_vel;

    int checks = 0, errors = 0;
    int cyc = 0, fe_cnt = 0, ov_cnt = 0, bv_cnt = 0;

    typedef struct { logic [7:0] data; int cycle; } exp_t;
    exp_t sb[$];

    midi_poly_decoder #(.CLKS_PER_BIT(CPB), .NUM_VOICES(NV)) dut (
        .clk(clk), .rst_n(rst_n), .midi_in(midi_in), .chan_sel(chan_sel), .omni(omni),
        .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err),
        .overflow(overflow), .voice_valid(voice_valid), .voice_note(voice_note),
        .voice_vel(voice_vel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every byte_valid must match the oldest expected byte and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (frame_err) fe_cnt++;
        if (overflow) ov_cnt++;
        if (byte_valid) begin
            bv_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL byte_unexpected: got %02h at cycle %0d", byte_data, cyc);
            end else begin
                e = sb.pop_front();
                if (byte_data !== e.data || cyc != e.cycle) begin
                    errors++;
                    $display("FAIL byte_rx: got %02h at cycle %0d, expected %02h at cycle %0d",
                             byte_data, cyc, e.data, e.cycle);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        tick(1);
        if (stop_bit) sb.push_back('{b, cyc + LAT});
        for (int i = 0; i < 10; i++) begin
            midi_in = fr[i];
            tick(CPB);
        end
        midi_in = 1'b1;
        if (!stop_bit) tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    function automatic logic [6:0] nt(input int i);
        return voice_note[7*i +: 7];
    endfunction

    function automatic logic [6:0] vl(input int i);
        return voice_vel[7*i +: 7];
    endfunction

    task automatic test_reset();
        tick(3);
        checks++;
        if ({byte_valid, byte_data, frame_err, overflow} !== 11'd0 || voice_valid !== '0 ||
            voice_note !== '0 || voice_vel !== '0) begin
            errors++;
            $display("FAIL reset_state: bv=%b bd=%02h fe=%b ov=%b vv=%b vn=%h vl=%h, expected all 0",
                     byte_valid, byte_data, frame_err, overflow, voice_valid, voice_note, voice_vel);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_note_on();
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0001 || nt(0) !== 7'h3C || vl(0) !== 7'h64) begin
            errors++;
            $display("FAIL note_on: vv=%b n0=%h v0=%h, expected 0001 3c 64", voice_valid, nt(0), vl(0));
        end
    endtask

    task automatic test_running_status();
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64); send_byte(8'h40); send_byte(8'h50);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0011 || nt(1) !== 7'h40 || vl(1) !== 7'h50) begin
            errors++;
            $display("FAIL rs_two_notes: vv=%b n1=%h v1=%h, expected 0011 40 50", voice_valid, nt(1), vl(1));
        end
        send_byte(8'h40); send_byte(8'h70);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0011 || vl(1) !== 7'h70 || nt(0) !== 7'h3C) begin
            errors++;
            $display("FAIL vel_update: vv=%b v1=%h n0=%h, expected 0011 70 3c", voice_valid, vl(1), nt(0));
        end
        send_byte(8'h3C); send_byte(8'h00);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0010 || nt(0) !== 7'h3C || vl(0) !== 7'h64) begin
            errors++;
            $display("FAIL vel0_off: vv=%b n0=%h v0=%h, expected 0010 3c 64 (stale)", voice_valid, nt(0), vl(0));
        end
        send_byte(8'h45); send_byte(8'h20);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0011 || nt(0) !== 7'h45 || vl(0) !== 7'h20) begin
            errors++;
            $display("FAIL slot_reuse: vv=%b n0=%h v0=%h, expected 0011 45 20", voice_valid, nt(0), vl(0));
        end
    endtask

    task automatic test_overflow();
        int ov0;
        do_reset();
        ov0 = ov_cnt;
        send_byte(8'h90);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h30 + 8'(i));
            send_byte(8'h10);
        end
        tick(2);
        checks++;
        if (voice_valid !== 4'b1111 || nt(0) !== 7'h30 || nt(1) !== 7'h31 ||
            nt(2) !== 7'h32 || nt(3) !== 7'h33) begin
            errors++;
            $display("FAIL table_full: vv=%b notes=%h, expected 1111 33/32/31/30", voice_valid, voice_note);
        end
        checks++;
        if (ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL overflow_pulses: got %0d, expected 1", ov_cnt - ov0);
        end
        send_byte(8'h80); send_byte(8'h31); send_byte(8'h00);
        tick(2);
        checks++;
        if (voice_valid !== 4'b1101) begin
            errors++;
            $display("FAIL note_off: vv=%b, expected 1101", voice_valid);
        end
    endtask

    task automatic test_channel();
        do_reset();
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0000) begin
            errors++;
            $display("FAIL chan_filter: vv=%b, expected 0000", voice_valid);
        end
        omni = 1'b1;
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0001 || nt(0) !== 7'h3C) begin
            errors++;
            $display("FAIL omni: vv=%b n0=%h, expected 0001 3c", voice_valid, nt(0));
        end
        omni = 1'b0;
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0001 || nt(0) !== 7'h3C || vl(0) !== 7'h64) begin
            errors++;
            $display("FAIL realtime_insert: vv=%b n0=%h v0=%h, expected 0001 3c 64", voice_valid, nt(0), vl(0));
        end
        send_byte(8'h90); send_byte(8'h40); send_byte(8'hF0); send_byte(8'h64);
        send_byte(8'h41); send_byte(8'h22);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0001) begin
            errors++;
            $display("FAIL sysex_drop: vv=%b, expected 0001", voice_valid);
        end
    endtask

    task automatic test_framing();
        int fe0, bv0;
        do_reset();
        fe0 = fe_cnt;
        bv0 = bv_cnt;
        send_frame(8'h55, 1'b0);
        tick(4);
        checks++;
        if (fe_cnt - fe0 != 1 || bv_cnt != bv0) begin
            errors++;
            $display("FAIL frame_err: fe=%0d bv=%0d, expected 1 0", fe_cnt - fe0, bv_cnt - bv0);
        end
        midi_in = 1'b0;
        tick(4);
        midi_in = 1'b1;
        tick(3 * CPB);
        checks++;
        if (fe_cnt - fe0 != 1 || bv_cnt != bv0) begin
            errors++;
            $display("FAIL glitch: fe=%0d bv=%0d, expected 1 0", fe_cnt - fe0, bv_cnt - bv0);
        end
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0001 || nt(0) !== 7'h3C) begin
            errors++;
            $display("FAIL after_glitch: vv=%b n0=%h, expected 0001 3c", voice_valid, nt(0));
        end
    endtask

    task automatic test_reset_abort();
        logic [9:0] fr;
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        tick(2);
        fr = {1'b1, 8'h90, 1'b0};
        tick(1);
        for (int i = 0; i < 8; i++) begin
            midi_in = fr[i];
            tick(CPB);
        end
        midi_in = fr[8];
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checks++;
        if ({byte_valid, byte_data, frame_err, overflow} !== 11'd0 || voice_valid !== '0 ||
            voice_note !== '0 || voice_vel !== '0) begin
            errors++;
            $display("FAIL abort_clear: bd=%02h vv=%b vn=%h vl=%h, expected all 0",
                     byte_data, voice_valid, voice_note, voice_vel);
        end
        tick(CPB - 3);
        midi_in = 1'b1;
        tick(2 * CPB);
        send_byte(8'h3C); send_byte(8'h64);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0000) begin
            errors++;
            $display("FAIL no_running_status: vv=%b, expected 0000", voice_valid);
        end
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        tick(2);
        checks++;
        if (voice_valid !== 4'b0001 || nt(0) !== 7'h3C || vl(0) !== 7'h64) begin
            errors++;
            $display("FAIL after_abort: vv=%b n0=%h v0=%h, expected 0001 3c 64", voice_valid, nt(0), vl(0));
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_overflow();
        test_channel();
        test_framing();
        test_reset_abort();
        tick(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bytes_missing: %0d expected bytes never arrived", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
